// File: rtl/sfp_accum.sv
// sfp_accum: special-function stage that sits right after pmem.
//
// It takes the 128-bit psum rows read out of pmem and adds acc_len rows
// together for each output, lane by lane, with signed saturation. ReLU is
// optional. Each result is placed on sfp_out and marked by a one-cycle
// sfp_valid pulse.
//
// Ports:
//   clk        : clock
//   reset      : synchronous, active-high reset
//   acc        : high in the cycle a pmem read is issued for this stage
//   pmem_rdata : pmem Q, valid one cycle after the read is issued
//   relu_en    : clamp negative results to zero (sampled on the emit cycle)
//   flush      : emit the current partial sum now
//   sfp_out    : accumulated result, lane i at [psum_bw*(i+1)-1:psum_bw*i]
//   sfp_valid  : one-cycle pulse when sfp_out is updated
//   busy       : a group is partially accumulated or a read beat is in flight
//   beat_cnt   : number of beats accumulated in the current group
module sfp_accum #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int acc_len = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   acc,
  input  logic [psum_bw*col-1:0] pmem_rdata,
  input  logic                   relu_en,
  input  logic                   flush,
  output logic [psum_bw*col-1:0] sfp_out,
  output logic                   sfp_valid,
  output logic                   busy,
  output logic [7:0]             beat_cnt
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  logic [0:0]                        state;
  logic                              acc_d;
  logic [col-1:0][psum_bw-1:0]       acc_q;
  logic [col-1:0][psum_bw-1:0]       sum_sat;
  logic [psum_bw*col-1:0]            out_next;
  logic [8:0]                        cnt_inc;
  logic                              last_beat;
  logic                              emit;

  // Each lane adds its incoming psum to the running sum one bit wider than
  // the lane, so that overflow can be seen. The result is then clamped to
  // the signed range. When the emit happens without a beat in this cycle
  // (a flush with acc_d low), the stored sum is sent out unchanged.
  for (genvar i = 0; i < col; i++) begin : g_lane
    logic [psum_bw-1:0] lane_in;
    logic [psum_bw:0]   wide;
    logic [psum_bw-1:0] sat;
    logic [psum_bw-1:0] pick;

    assign lane_in = pmem_rdata[i*psum_bw +: psum_bw];
    assign wide    = {acc_q[i][psum_bw-1], acc_q[i]} + {lane_in[psum_bw-1], lane_in};

    // The top two bits differ only on overflow. The extra sign bit then
    // says which limit the result went past.
    always_comb begin
      sat = wide[psum_bw-1:0];
      if (wide[psum_bw] != wide[psum_bw-1]) begin
        sat = wide[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                            : {1'b0, {(psum_bw-1){1'b1}}};
      end
    end

    assign sum_sat[i] = sat;
    assign pick       = acc_d ? sat : acc_q[i];
    assign out_next[i*psum_bw +: psum_bw] = (relu_en && pick[psum_bw-1]) ? '0 : pick;
  end

  // A group ends on its acc_len-th beat, or on flush whenever there is
  // something to flush. This is either a beat arriving now or a partial sum
  // that is already stored.
  assign cnt_inc   = {1'b0, beat_cnt} + 9'd1;
  assign last_beat = acc_d && (cnt_inc == 9'(acc_len));
  assign emit      = last_beat || (flush && (acc_d || (state == ACCUM)));
  assign busy      = acc_d || (state == ACCUM);

  // acc_d lines up the acc strobe with the one-cycle pmem read latency.
  // An emit clears the running sum in the same cycle. So a beat that arrives
  // in the next cycle starts the next group without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_d     <= 1'b0;
      acc_q     <= '0;
      beat_cnt  <= 8'd0;
      sfp_out   <= '0;
      sfp_valid <= 1'b0;
      state     <= IDLE;
    end else begin
      acc_d     <= acc;
      sfp_valid <= 1'b0;
      if (emit) begin
        sfp_out   <= out_next;
        sfp_valid <= 1'b1;
        acc_q     <= '0;
        beat_cnt  <= 8'd0;
        state     <= IDLE;
      end else if (acc_d) begin
        acc_q     <= sum_sat;
        beat_cnt  <= cnt_inc[7:0];
        state     <= ACCUM;
      end
    end
  end

endmodule

// File: tb/tb_sfp_accum.sv
// tb_sfp_accum: self-checking bench for sfp_accum.
// Group tests are table-driven. Back-to-back, flush and reset corner cases
// are hand-written sequences. Expected results are queued when the stimulus
// is driven, and a negedge monitor checks them against each sfp_valid pulse.
module tb_sfp_accum;

  localparam int W = 128;

  logic          clk;
  logic          reset;
  logic          acc;
  logic [W-1:0]  pmem_rdata;
  logic          relu_en;
  logic          flush;
  logic [W-1:0]  sfp_out;
  logic          sfp_valid;
  logic          busy;
  logic [7:0]    beat_cnt;

  sfp_accum #(.psum_bw(16), .col(8), .acc_len(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .acc        (acc),
    .pmem_rdata (pmem_rdata),
    .relu_en    (relu_en),
    .flush      (flush),
    .sfp_out    (sfp_out),
    .sfp_valid  (sfp_valid),
    .busy       (busy),
    .beat_cnt   (beat_cnt)
  );

  typedef struct {
    int          beats;
    logic [15:0] l0;
    logic [15:0] rest;
    bit          relu;
    logic [15:0] e0;
    logic [15:0] erest;
    string       name;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
    string        name;
  } exp_t;

  exp_t         sbq[$];
  int           assertCount = 0;
  int           failCount   = 0;
  int           cyc         = 0;
  int           lastCyc     = 0;
  logic [W-1:0] pending     = '0;
  vec_t         vecs[6];

  // Free-running clock and a cycle counter that the driver and the monitor
  // share for latency checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [W-1:0] lanes(input logic [15:0] l0, input logic [15:0] rest);
    return {{7{rest}}, l0};
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // This task runs for one cycle. It sets up the read issued now (acc) and
  // puts last cycle's read data on pmem_rdata, the way pmem would. When no
  // read is issued, the next data word is random garbage that must be ignored.
  task automatic applyStimulus(input bit a, input logic [W-1:0] d, input bit fl);
    @(negedge clk);
    pmem_rdata = pending;
    pending    = a ? d : {$urandom, $urandom, $urandom, $urandom};
    acc        = a;
    flush      = fl;
    lastCyc    = cyc;
  endtask

  task automatic expectPulse(input logic [W-1:0] d, input int at, input string name);
    exp_t e;
    e.data = d;
    e.cyc  = at;
    e.name = name;
    sbq.push_back(e);
  endtask

  // Monitor: each sfp_valid pulse must match the oldest expected result, both
  // in data and in the cycle it appears.
  always @(negedge clk) begin
    if (sfp_valid) begin
      if (sbq.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected_pulse actual=%h required=no_pulse (cycle %0d)", sfp_out, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        checkOutput({e.name, "_data"}, sfp_out, e.data);
        checkOutput({e.name, "_cycle"}, W'(cyc), W'(e.cyc));
      end
    end
  end

  initial begin
    vecs[0] = '{9, 16'h0003, 16'h0003, 1'b0, 16'h001B, 16'h001B, "plus3"};
    vecs[1] = '{9, 16'hFFFB, 16'h0005, 1'b1, 16'h0000, 16'h002D, "relu_on"};
    vecs[2] = '{9, 16'hFFFB, 16'h0005, 1'b0, 16'hFFD3, 16'h002D, "relu_off"};
    vecs[3] = '{9, 16'h7000, 16'h7000, 1'b0, 16'h7FFF, 16'h7FFF, "sat_pos"};
    vecs[4] = '{9, 16'h9000, 16'h9000, 1'b0, 16'h8000, 16'h8000, "sat_neg"};
    vecs[5] = '{9, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 16'h0009, "relu_mix"};

    reset = 1'b1; acc = 1'b0; flush = 1'b0; relu_en = 1'b0; pmem_rdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_sfp_out", sfp_out, '0);
    checkOutput("reset_sfp_valid", W'(sfp_valid), '0);
    checkOutput("reset_beat_cnt", W'(beat_cnt), '0);
    checkOutput("reset_busy", W'(busy), '0);
    reset = 1'b0;

    // Table-driven groups: each group is acc_len beats of constant lane
    // data, and the result is expected 2 cycles after the last acc.
    for (int v = 0; v < 6; v++) begin
      relu_en = vecs[v].relu;
      for (int b = 0; b < vecs[v].beats; b++)
        applyStimulus(1'b1, lanes(vecs[v].l0, vecs[v].rest), 1'b0);
      expectPulse(lanes(vecs[v].e0, vecs[v].erest), lastCyc + 2, vecs[v].name);
      repeat (3) applyStimulus(1'b0, '0, 1'b0);
      checkOutput({vecs[v].name, "_beat_cnt_idle"}, W'(beat_cnt), '0);
      checkOutput({vecs[v].name, "_busy_idle"}, W'(busy), '0);
    end
    relu_en = 1'b0;

    // Back-to-back: 18 beats with no gaps. The values 1..18 give two
    // groups, summing to 45 and 126.
    begin
      int s;
      s = 0;
      for (int b = 1; b <= 18; b++) begin
        applyStimulus(1'b1, {8{16'(b)}}, 1'b0);
        s += b;
        if (b == 9 || b == 18) begin
          expectPulse({8{16'(s)}}, lastCyc + 2, (b == 9) ? "b2b_first" : "b2b_second");
          s = 0;
        end
        if (b == 5) checkOutput("b2b_busy_mid", W'(busy), W'(1));
      end
      repeat (3) applyStimulus(1'b0, '0, 1'b0);
    end

    // Flush with no beat in flight: 4 beats of +2 are waiting, then flush.
    for (int b = 0; b < 4; b++) applyStimulus(1'b1, {8{16'h0002}}, 1'b0);
    repeat (2) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("flush_partial_cnt", W'(beat_cnt), W'(4));
    checkOutput("flush_partial_busy", W'(busy), W'(1));
    applyStimulus(1'b0, '0, 1'b1);
    expectPulse({8{16'h0008}}, lastCyc + 1, "flush_partial");
    repeat (2) applyStimulus(1'b0, '0, 1'b0);

    // Flush in IDLE must be a no-op.
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("flush_idle_valid", W'(sfp_valid), '0);
    checkOutput("flush_idle_out", sfp_out, {8{16'h0008}});
    applyStimulus(1'b0, '0, 1'b0);

    // Flush in the same cycle as the 3rd beat of +1: that beat is added
    // first, then the sum is emitted.
    for (int b = 0; b < 3; b++) applyStimulus(1'b1, {8{16'h0001}}, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    expectPulse({8{16'h0003}}, lastCyc + 1, "flush_with_beat");
    repeat (3) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("flush_with_beat_cnt", W'(beat_cnt), '0);

    // Reset in the middle of a group drops the partial sum with no pulse.
    // Then a fresh group must start from zero.
    for (int b = 0; b < 5; b++) applyStimulus(1'b1, {8{16'h0001}}, 1'b0);
    repeat (2) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("pre_reset_cnt", W'(beat_cnt), W'(5));
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("midreset_sfp_out", sfp_out, '0);
    checkOutput("midreset_beat_cnt", W'(beat_cnt), '0);
    checkOutput("midreset_busy", W'(busy), '0);
    for (int b = 0; b < 9; b++) applyStimulus(1'b1, {8{16'h0001}}, 1'b0);
    expectPulse({8{16'h0009}}, lastCyc + 2, "after_reset");
    repeat (3) applyStimulus(1'b0, '0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles. Any entry
    // still waiting is a missing pulse.
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    while (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s_missing actual=no_pulse required=%h", e.name, e.data);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
